// File: rtl/auth_rx.sv
// auth_rx: 8N1 serial command receiver plus power authorization FSM.
// Ports: clk, RST (async, active-high), RX (serial in), rider_off (load
// cells report no rider); pwr_up (balance enable), rx_data (last good
// byte), rx_rdy (new-byte pulse), frm_err (bad-stop-bit pulse).
module auth_rx #(
    parameter int BAUD_DIV = 5208
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       RX,
    input  logic       rider_off,
    output logic       pwr_up,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frm_err
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
    localparam logic [7:0] CMD_GO = 8'h47;
    localparam logic [7:0] CMD_STOP = 8'h53;

    typedef enum logic {
        RX_IDLE,
        RX_RCV
    } rx_state_e;

    typedef enum logic [1:0] {
        AUTH_OFF,
        AUTH_PWR1,
        AUTH_PWR2
    } auth_state_e;

    logic rx_meta_q;
    logic rx_s_q;
    logic rx_prev_q;
    logic fall;

    rx_state_e rx_st_q, rx_st_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [3:0] bit_q, bit_d;
    logic [8:0] shreg_q, shreg_d;
    logic [7:0] data_q, data_d;
    logic rdy_q, rdy_d;
    logic ferr_q, ferr_d;

    auth_state_e auth_q, auth_d;
    logic pwr_q;

    // Synchronizer and edge flops idle high so reset never fakes a start bit.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign fall = rx_prev_q & ~rx_s_q;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            rx_st_q <= RX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            rx_st_q <= rx_st_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            ferr_q  <= ferr_d;
        end
    end

    // The shift register is seeded with a marker in bit 8; after the eight
    // data samples the marker sits in bit 0, flagging a complete byte.
    always_comb begin
        rx_st_d = rx_st_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        rdy_d   = 1'b0;
        ferr_d  = 1'b0;
        unique case (rx_st_q)
            RX_IDLE: begin
                if (fall) begin
                    rx_st_d = RX_RCV;
                    baud_d  = HALF_M1;
                    bit_d   = 4'd0;
                    shreg_d = 9'h100;
                end
            end
            RX_RCV: begin
                if (baud_q != '0) begin
                    baud_d = baud_q - 1'b1;
                end else begin
                    baud_d = FULL_M1;
                    bit_d  = bit_q + 4'd1;
                    if (bit_q == 4'd0) begin
                        if (rx_s_q) begin
                            rx_st_d = RX_IDLE;
                        end
                    end else if (bit_q == 4'd9) begin
                        rx_st_d = RX_IDLE;
                        if (rx_s_q) begin
                            if (shreg_q[0]) begin
                                data_d = shreg_q[8:1];
                            end
                            rdy_d = shreg_q[0];
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        shreg_d = {rx_s_q, shreg_q[8:1]};
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            auth_q <= AUTH_OFF;
            pwr_q  <= 1'b0;
        end else begin
            auth_q <= auth_d;
            pwr_q  <= (auth_q != AUTH_OFF);
        end
    end

    // PWR2 is "stop requested, rider still on": it drops to OFF as soon as
    // the rider leaves, unless a fresh go command arrives that same cycle.
    always_comb begin
        auth_d = auth_q;
        case (auth_q)
            AUTH_OFF: begin
                if (rdy_q && data_q == CMD_GO) begin
                    auth_d = AUTH_PWR1;
                end
            end
            AUTH_PWR1: begin
                if (rdy_q && data_q == CMD_STOP) begin
                    auth_d = rider_off ? AUTH_OFF : AUTH_PWR2;
                end
            end
            AUTH_PWR2: begin
                if (rdy_q && data_q == CMD_GO) begin
                    auth_d = AUTH_PWR1;
                end else if (rider_off) begin
                    auth_d = AUTH_OFF;
                end
            end
            default: auth_d = AUTH_OFF;
        endcase
    end

    assign pwr_up  = pwr_q;
    assign rx_data = data_q;
    assign rx_rdy  = rdy_q;
    assign frm_err = ferr_q;

endmodule

// File: tb/tb_auth_rx.sv
// tb_auth_rx: randomized and directed stimulus for auth_rx against a
// behavioural model of frame timing and power authorization.
module tb_auth_rx;

    localparam int BD = 16;
    localparam int LAT = 2 + BD / 2 + 9 * BD;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       RX = 1'b1;
    logic       rider_off = 1'b0;
    logic       pwr_up;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       frm_err;

    auth_rx #(.BAUD_DIV(BD)) dut (
        .clk      (clk),
        .RST      (RST),
        .RX       (RX),
        .rider_off(rider_off),
        .pwr_up   (pwr_up),
        .rx_data  (rx_data),
        .rx_rdy   (rx_rdy),
        .frm_err  (frm_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        int         c;
        logic [7:0] d;
    } ev_t;

    ev_t  rdy_q[$];
    int   ferr_q[$];
    int   pwr_q[$];
    logic pwr_prev = 1'b0;
    int   both = 0;

    always @(negedge clk) begin
        if (rx_rdy) rdy_q.push_back('{cyc, rx_data});
        if (frm_err) ferr_q.push_back(cyc);
        if (rx_rdy && frm_err) both++;
        if (pwr_up !== pwr_prev) pwr_q.push_back(cyc);
        pwr_prev = pwr_up;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Model: authorized / stop-pending flags and the last good byte.
    bit         m_auth = 0;
    bit         m_pend = 0;
    logic [7:0] m_data = 8'h00;

    function automatic void m_byte(input logic [7:0] b);
        if (b == 8'h47) begin
            m_auth = 1;
            m_pend = 0;
        end else if (b == 8'h53 && m_auth && !m_pend) begin
            if (rider_off) m_auth = 0;
            else m_pend = 1;
        end
    endfunction

    task automatic set_rider(input logic v);
        rider_off = v;
        if (m_pend && v) begin
            m_auth = 0;
            m_pend = 0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              output int t0);
        t0 = cyc + 1;
        RX = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BD) @(negedge clk);
        end
        RX = stop;
        repeat (BD) @(negedge clk);
        RX = 1'b1;
    endtask

    task automatic check_frame(input string tag, input int t0,
                               input logic [7:0] b, input logic stop);
        int e;
        e = t0 + LAT;
        if (stop) begin
            m_byte(b);
            m_data = b;
        end
        chk({tag, ".rdy_n"}, rdy_q.size(), stop ? 1 : 0);
        chk({tag, ".ferr_n"}, ferr_q.size(), stop ? 0 : 1);
        if (stop && rdy_q.size() > 0) begin
            chk({tag, ".rdy_cyc"}, rdy_q[0].c, e);
            chk({tag, ".rdy_data"}, rdy_q[0].d, b);
        end
        if (!stop && ferr_q.size() > 0)
            chk({tag, ".ferr_cyc"}, ferr_q[0], e);
        chk({tag, ".rx_data"}, rx_data, m_data);
        chk({tag, ".pwr"}, pwr_up, m_auth);
        rdy_q.delete();
        ferr_q.delete();
    endtask

    function automatic int first_pwr();
        return (pwr_q.size() > 0) ? pwr_q[0] : -1;
    endfunction

    int t0;
    int p;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst.pwr", pwr_up, 0);
        chk("rst.rdy", rx_rdy, 0);
        chk("rst.ferr", frm_err, 0);
        chk("rst.data", rx_data, 0);
        RST = 1'b0;
        repeat (5) @(negedge clk);

        // Partial 0x47 frame cut by reset.
        RX = 1'b0;
        repeat (BD) @(negedge clk);
        RX = 1'b1;
        repeat (2 * BD) @(negedge clk);
        RST = 1'b1;
        #1;
        chk("mid.pwr", pwr_up, 0);
        chk("mid.rdy", rx_rdy, 0);
        chk("mid.data", rx_data, 0);
        @(negedge clk);
        RST = 1'b0;
        repeat (8 * BD) @(negedge clk);
        chk("mid.no_rdy", rdy_q.size(), 0);
        chk("mid.no_ferr", ferr_q.size(), 0);
        pwr_q.delete();

        send_frame(8'h47, 1'b1, t0);
        check_frame("g1", t0, 8'h47, 1'b1);
        chk("g1.rise_cyc", first_pwr(), t0 + LAT + 2);
        pwr_q.delete();

        send_frame(8'h53, 1'b1, t0);
        check_frame("s_on", t0, 8'h53, 1'b1);
        chk("s_on.no_chg", pwr_q.size(), 0);
        set_rider(1'b1);
        p = cyc;
        repeat (4) @(negedge clk);
        chk("ro.fall_cyc", first_pwr(), p + 2);
        chk("ro.pwr", pwr_up, m_auth);
        pwr_q.delete();

        send_frame(8'h47, 1'b1, t0);
        check_frame("g2", t0, 8'h47, 1'b1);
        pwr_q.delete();
        send_frame(8'h53, 1'b1, t0);
        check_frame("s_off", t0, 8'h53, 1'b1);
        chk("s_off.fall_cyc", first_pwr(), t0 + LAT + 2);
        pwr_q.delete();
        set_rider(1'b0);

        send_frame(8'h47, 1'b0, t0);
        check_frame("ferr", t0, 8'h47, 1'b0);
        chk("ferr.no_chg", pwr_q.size(), 0);

        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (3 * BD) @(negedge clk);
        chk("glitch.rdy", rdy_q.size(), 0);
        chk("glitch.ferr", ferr_q.size(), 0);

        send_frame(8'hA5, 1'b1, t0);
        check_frame("a5", t0, 8'hA5, 1'b1);

        pwr_q.delete();
        send_frame(8'h47, 1'b1, t0);
        check_frame("b2b0", t0, 8'h47, 1'b1);
        send_frame(8'h53, 1'b1, t0);
        check_frame("b2b1", t0, 8'h53, 1'b1);
        send_frame(8'h47, 1'b1, t0);
        check_frame("b2b2", t0, 8'h47, 1'b1);
        chk("b2b.pwr_edges", pwr_q.size(), 1);

        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            logic       stop;
            int         r;
            repeat ($urandom_range(0, 12)) @(negedge clk);
            set_rider($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 3);
            if (r == 0) b = 8'h47;
            else if (r == 1) b = 8'h53;
            else b = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            send_frame(b, stop, t0);
            check_frame($sformatf("rnd%0d", n), t0, b, stop);
        end

        set_rider(1'b0);
        send_frame(8'h47, 1'b1, t0);
        check_frame("ar.g", t0, 8'h47, 1'b1);
        RX = 1'b0;
        repeat (2 * BD) @(negedge clk);
        RST = 1'b1;
        #1;
        chk("ar.pwr", pwr_up, 0);
        chk("ar.data", rx_data, 0);
        chk("ar.rdy", rx_rdy, 0);
        @(negedge clk);
        RST = 1'b0;
        RX = 1'b1;
        m_auth = 0;
        m_pend = 0;
        m_data = 8'h00;
        repeat (4 * BD) @(negedge clk);
        rdy_q.delete();
        ferr_q.delete();
        send_frame(8'h53, 1'b1, t0);
        check_frame("ar.s", t0, 8'h53, 1'b1);

        chk("no_overlap", both, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
